// File: rtl/add_block_accumulator.sv
// Accumulates K consecutive (N+1)-bit signed sums into one block total on a valid/ready port.
// Define ADD_BLOCK_ACC_SAT_EN to clamp the total to OW bits (else it wraps).
module add_block_accumulator #(
  parameter int unsigned N  = 4,
  parameter int unsigned K  = 4,
  parameter int unsigned OW = N + 1 + $clog2(K)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [N:0]        s_in,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     clr,
  output logic signed [OW-1:0]     a,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [$clog2(K+1)-1:0]   cnt,
  output logic                     ovf
);

  localparam int unsigned AW = N + 1 + $clog2(K);
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned XW = (OW > AW) ? OW : AW;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e                state_q;
  logic signed [AW-1:0]  acc_q;
  logic [CW-1:0]         cnt_q;
  logic signed [OW-1:0]  a_q;
  logic                  a_valid_q;
  logic                  s_ready_q;
  logic                  ovf_q;

  logic signed [AW-1:0]  samp_ext;
  logic signed [AW-1:0]  acc_add;
  logic [CW-1:0]         cnt_add;
  logic signed [XW-1:0]  sum_x;
  logic signed [OW-1:0]  fmt_a;
  logic                  fmt_ovf;
  logic                  accept;

`ifdef ADD_BLOCK_ACC_SAT_EN
  localparam logic signed [XW-1:0] MaxV = XW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [XW-1:0] MinV = ~MaxV;
`endif

  always_comb begin
    samp_ext = AW'(s_in);
    acc_add  = (state_q == StIdle) ? samp_ext : acc_q + samp_ext;
    cnt_add  = cnt_q + CW'(1);
    accept   = s_valid && s_ready_q;
    // Widen before formatting so a wider OW is a plain sign-extension.
    sum_x    = XW'(acc_add);
    fmt_a    = sum_x[OW-1:0];
    fmt_ovf  = 1'b0;
`ifdef ADD_BLOCK_ACC_SAT_EN
    if (sum_x > MaxV) begin
      fmt_a   = MaxV[OW-1:0];
      fmt_ovf = 1'b1;
    end else if (sum_x < MinV) begin
      fmt_a   = MinV[OW-1:0];
      fmt_ovf = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (clr) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StAcc: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_add;
            cnt_q <= cnt_add;
            if (cnt_add == CW'(K)) begin
              state_q   <= StDone;
              a_q       <= fmt_a;
              ovf_q     <= fmt_ovf;
              a_valid_q <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StDone: begin
          // No bypass: a new block can only start the cycle after the handshake.
          if (a_ready) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            a_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            ovf_q     <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          acc_q     <= '0;
          cnt_q     <= '0;
          a_valid_q <= 1'b0;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign a       = a_q;
  assign a_valid = a_valid_q;
  assign cnt     = cnt_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_add_block_accumulator.sv
// Directed bench for add_block_accumulator: OW=7 main instance plus an OW=6 instance for formatting.
module tb_add_block_accumulator;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [4:0] s_in;
  logic              s_valid;
  logic              clr;
  logic              a_ready;

  logic              s_ready1, a_valid1, ovf1;
  logic signed [6:0] a1;
  logic [2:0]        cnt1;
  logic              s_ready2, a_valid2, ovf2;
  logic signed [5:0] a2;
  logic [2:0]        cnt2;

  int errors = 0;
  int checks = 0;

`ifdef ADD_BLOCK_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  always #5 clk = ~clk;

  add_block_accumulator #(.N(4), .K(4), .OW(7)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready1),
    .clr(clr), .a(a1), .a_valid(a_valid1), .a_ready(a_ready), .cnt(cnt1), .ovf(ovf1)
  );

  add_block_accumulator #(.N(4), .K(4), .OW(6)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid), .s_ready(s_ready2),
    .clr(clr), .a(a2), .a_valid(a_valid2), .a_ready(a_ready), .cnt(cnt2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [4:0] v);
    s_valid = 1'b1;
    s_in    = v;
    step();
    s_valid = 1'b0;
  endtask

  task automatic feed4(input logic signed [4:0] v0, input logic signed [4:0] v1,
                       input logic signed [4:0] v2, input logic signed [4:0] v3);
    send(v0);
    send(v1);
    send(v2);
    send(v3);
  endtask

  task automatic handshake();
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_in = '0; s_valid = 1'b0; clr = 1'b0; a_ready = 1'b0;
    step();
    step();
    check("rst_s_ready", s_ready1, 0);
    check("rst_a_valid", a_valid1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_a", a1, 0);
    check("rst_ovf", ovf1, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_s_ready", s_ready1, 1);

    // Basic block 3,-5,7,1
    send(3);
    check("blk1_cnt1", cnt1, 1);
    send(-5);
    send(7);
    check("blk1_cnt3_no_valid", a_valid1, 0);
    send(1);
    check("blk1_a_valid", a_valid1, 1);
    check("blk1_a", a1, 6);
    check("blk1_cnt", cnt1, 4);
    check("blk1_s_ready", s_ready1, 0);
    handshake();
    check("blk1_post_a_valid", a_valid1, 0);
    check("blk1_post_cnt", cnt1, 0);
    check("blk1_post_s_ready", s_ready1, 1);

    // Positive extreme; OW=6 instance saturates or wraps
    feed4(15, 15, 15, 15);
    check("pos_a", a1, 60);
    check("pos_ovf", ovf1, 0);
    check("pos_a_ow6", a2, Sat ? 31 : -4);
    check("pos_ovf_ow6", ovf2, Sat ? 1 : 0);
    handshake();

    // Negative extreme
    feed4(-16, -16, -16, -16);
    check("neg_a", a1, -64);
    check("neg_ovf", ovf1, 0);
    check("neg_a_ow6", a2, Sat ? -32 : 0);
    check("neg_ovf_ow6", ovf2, Sat ? 1 : 0);
    handshake();

    // Backpressure with S_VALID held high
    feed4(2, 2, 2, 2);
    s_valid = 1'b1;
    s_in    = 5;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_s_ready", s_ready1, 0);
      check("bp_a", a1, 8);
      check("bp_cnt", cnt1, 4);
      check("bp_a_valid", a_valid1, 1);
    end
    s_valid = 1'b0;
    handshake();
    check("bp_post_cnt", cnt1, 0);
    check("bp_post_a_valid", a_valid1, 0);

    // Gaps then CLR with a sample presented
    send(4);
    step();
    step();
    check("gap_cnt_hold", cnt1, 1);
    send(4);
    step();
    check("gap_cnt", cnt1, 2);
    clr = 1'b1; s_valid = 1'b1; s_in = 9;
    step();
    clr = 1'b0; s_valid = 1'b0;
    check("clr_cnt", cnt1, 0);
    check("clr_s_ready", s_ready1, 1);
    check("clr_a_valid", a_valid1, 0);
    feed4(1, 1, 1, 1);
    check("clr_next_a", a1, 4);
    check("clr_next_a_valid", a_valid1, 1);
    // CLR in DONE drops the unconsumed result
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_done_a_valid", a_valid1, 0);
    check("clr_done_cnt", cnt1, 0);

    // Asynchronous reset mid-block
    send(2);
    send(3);
    check("ar_cnt_before", cnt1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_cnt", cnt1, 0);
    check("ar_s_ready", s_ready1, 0);
    check("ar_a_valid", a_valid1, 0);
    check("ar_a", a1, 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_post_s_ready", s_ready1, 1);
    feed4(2, 3, 4, 5);
    check("ar_fresh_a", a1, 14);
    check("ar_fresh_a_valid", a_valid1, 1);
    check("ar_fresh_a_ow6", a2, 14);
    handshake();
    check("ar_fresh_post_cnt", cnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
